// File: rtl/circ_mvm_seq_if.sv
// Stream and multiplier-side signal bundle for circ_mvm_seq.
// slave = the sequencer, master = whatever drives it (source, sink and multiplier).
interface circ_mvm_seq_if #(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [WORD_WIDTH-1:0]                in_data;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  mvm_vec;
  logic                                 mvm_reset;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  mvm_result;
  logic                                 mvm_valid;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [WORD_WIDTH-1:0]                out_data;
  logic                                 out_last;
  logic                                 busy;

  modport slave (
    input  in_valid, in_data, mvm_result, mvm_valid, out_ready,
    output in_ready, mvm_vec, mvm_reset, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, mvm_result, mvm_valid, out_ready,
    input  in_ready, mvm_vec, mvm_reset, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/circ_mvm_seq.sv
// Serial-to-parallel loader / parallel-to-serial drainer around a circulant M31 multiplier.
// Optional macro CIRC_MVM_SEQ_CANON_EN maps the non-canonical word 2^31-1 to 0 on input.
module circ_mvm_seq #(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
) (
  input  logic            clk,
  input  logic            reset,
  circ_mvm_seq_if.slave   bus
);
  localparam int IW = (MTX_SIZE > 1) ? $clog2(MTX_SIZE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(MTX_SIZE - 1);

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t                               state_q;
  logic [IW-1:0]                        idx_q;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  vec_q;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  res_q;
  logic                                 mvm_reset_q;
  logic [WORD_WIDTH-1:0]                word_d;
  logic                                 idx_last;

`ifdef CIRC_MVM_SEQ_CANON_EN
  localparam logic [WORD_WIDTH-1:0] M31_P = WORD_WIDTH'(32'h7FFF_FFFF);
  assign word_d = (bus.in_data == M31_P) ? '0 : bus.in_data;
`else
  assign word_d = bus.in_data;
`endif

  assign idx_last = (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      vec_q       <= '0;
      res_q       <= '0;
      mvm_reset_q <= 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.in_valid) begin
            vec_q[idx_q] <= word_d;
            if (idx_last) begin
              state_q     <= RUN;
              idx_q       <= '0;
              mvm_reset_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        RUN: begin
          // Result is captured on the very edge that re-arms the multiplier hold.
          if (bus.mvm_valid) begin
            res_q       <= bus.mvm_result;
            state_q     <= DRAIN;
            mvm_reset_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (idx_last) begin
              state_q <= LOAD;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= LOAD;
          idx_q       <= '0;
          mvm_reset_q <= 1'b1;
        end
      endcase
    end
  end

  // Handshake-facing outputs are forced quiet while reset is held, even before its first edge.
  assign bus.in_ready  = (state_q == LOAD) && !reset;
  assign bus.out_valid = (state_q == DRAIN) && !reset;
  assign bus.out_last  = bus.out_valid && idx_last;
  assign bus.out_data  = res_q[idx_q];
  assign bus.busy      = ((state_q == RUN) || (state_q == DRAIN)) && !reset;
  assign bus.mvm_reset = mvm_reset_q || reset;
  assign bus.mvm_vec   = vec_q;
endmodule
